// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  serial_addsub : bit-serial adder/subtractor, LSB first, one bit per clock.
//  Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
//  Revision 1.0
// ============================================================================
module serial_addsub #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(W - 1);

    state_t             r_state;
    logic [W-1:0]       r_sh_a;
    logic [W-1:0]       r_sh_b;
    logic [W-1:0]       r_sum_sh;
    logic [W-1:0]       r_s;
    logic               r_carry;
    logic               r_co;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sum;
    logic               w_cout;
    logic [W-1:0]       w_sum_next;

    assign w_sum  = r_sh_a[0] ^ r_sh_b[0] ^ r_carry;
    assign w_cout = (r_sh_a[0] & r_sh_b[0]) | (r_sh_a[0] & r_carry) | (r_sh_b[0] & r_carry);

    // Sum bits enter at the MSB so that after W shifts bit 0 sits at the LSB.
    if (W == 1) begin : g_w1
        assign w_sum_next = w_sum;
    end else begin : g_wn
        assign w_sum_next = {w_sum, r_sum_sh[W-1:1]};
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_sum_sh <= '0;
            r_s      <= '0;
            r_carry  <= 1'b0;
            r_co     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + ~ci, so invert b and the borrow up front.
                        r_sh_a   <= a;
                        r_sh_b   <= sub ? ~b : b;
                        r_carry  <= sub ? ~ci : ci;
                        r_sum_sh <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_carry  <= w_cout;
                    r_sum_sh <= w_sum_next;
                    r_sh_a   <= r_sh_a >> 1;
                    r_sh_b   <= r_sh_b >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_s     <= w_sum_next;
                        r_co    <= w_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                        r_ovf   <= r_carry ^ w_cout;
`endif
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_co;

endmodule
`default_nettype wire
